// File: rtl/axil_initiator.sv
// axil_initiator
//   AXI4-Lite master turning a single-beat command/response interface into
//   AXI4-Lite read or write transactions. One transaction is outstanding at
//   a time and every accepted command yields exactly one response.
//
//   Optional feature: define AXIL_INITIATOR_TIMEOUT_EN to abort a transaction
//   after TIMEOUT_CYCLES waiting cycles (response flagged with rsp_timeout=1,
//   rsp_resp=2'b10). Without it the block waits indefinitely.
//
// Ports
//   AXI_clock, AXI_reset      clock, asynchronous active-high reset
//   cmd_*                     command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                     response out (valid/ready, rdata, resp, timeout)
//   AXIL_aw*, AXIL_w*, AXIL_b*  AXI4-Lite write channels
//   AXIL_ar*, AXIL_r*           AXI4-Lite read channels
module axil_initiator #(
  parameter logic [2:0]  PROT           = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        AXI_clock,
  input  logic        AXI_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] AXIL_awaddr,
  output logic [2:0]  AXIL_awprot,
  output logic        AXIL_awvalid,
  input  logic        AXIL_awready,
  output logic [31:0] AXIL_wdata,
  output logic [3:0]  AXIL_wstrb,
  output logic        AXIL_wvalid,
  input  logic        AXIL_wready,
  input  logic [1:0]  AXIL_bresp,
  input  logic        AXIL_bvalid,
  output logic        AXIL_bready,
  output logic [31:0] AXIL_araddr,
  output logic [2:0]  AXIL_arprot,
  output logic        AXIL_arvalid,
  input  logic        AXIL_arready,
  input  logic [31:0] AXIL_rdata,
  input  logic [1:0]  AXIL_rresp,
  input  logic        AXIL_rvalid,
  output logic        AXIL_rready
);

  generate
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
      $error("axil_initiator: TIMEOUT_CYCLES must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic        cmd_ready_reg, cmd_ready_next;
  logic        awvalid_reg, awvalid_next;
  logic        wvalid_reg, wvalid_next;
  logic        bready_reg, bready_next;
  logic        arvalid_reg, arvalid_next;
  logic        rready_reg, rready_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]  rsp_resp_reg, rsp_resp_next;
  logic        accept;
  logic        timeout_hit;

  assign accept = cmd_valid && cmd_ready_reg;

`ifdef AXIL_INITIATOR_TIMEOUT_EN
  logic [31:0] count_reg, count_next;
  logic        rsp_timeout_reg, rsp_timeout_next;
  logic        active;

  assign active = (state_reg == WR_ADDR_DATA) || (state_reg == WR_RESP) ||
                  (state_reg == RD_ADDR) || (state_reg == RD_DATA);
  // Counter was cleared on accept, so this cycle is the TIMEOUT_CYCLES-th wait.
  assign timeout_hit = active && (count_reg == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_next = count_reg;
    if (accept)
      count_next = '0;
    else if (active)
      count_next = count_reg + 32'd1;
  end

  always_ff @(posedge AXI_clock or posedge AXI_reset) begin
    if (AXI_reset) begin
      count_reg       <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      count_reg       <= count_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  assign rsp_timeout = rsp_timeout_reg;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge AXI_clock or posedge AXI_reset) begin
    if (AXI_reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      cmd_ready_reg <= 1'b1;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      cmd_ready_reg <= cmd_ready_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:
        if (accept) state_next = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA:
        // A channel is done if it already handshook or handshakes now.
        if ((!awvalid_reg || AXIL_awready) && (!wvalid_reg || AXIL_wready))
          state_next = WR_RESP;
      WR_RESP:
        if (AXIL_bvalid) state_next = RESPOND;
      RD_ADDR:
        if (AXIL_arready) state_next = RD_DATA;
      RD_DATA:
        if (AXIL_rvalid) state_next = RESPOND;
      RESPOND:
        if (rsp_ready) state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
    if (timeout_hit) state_next = RESPOND;
  end

  // Next values of the registered outputs.
  always_comb begin
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;
`ifdef AXIL_INITIATOR_TIMEOUT_EN
    rsp_timeout_next = rsp_timeout_reg;
`endif
    cmd_ready_next = (state_next == IDLE);
    case (state_reg)
      IDLE:
        if (accept) begin
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          wstrb_next = cmd_wstrb;
          if (cmd_write) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            arvalid_next = 1'b1;
          end
        end
      WR_ADDR_DATA: begin
        if (AXIL_awready) awvalid_next = 1'b0;
        if (AXIL_wready)  wvalid_next  = 1'b0;
        if (state_next == WR_RESP) bready_next = 1'b1;
      end
      WR_RESP:
        if (AXIL_bvalid) begin
          bready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_resp_next  = AXIL_bresp;
`ifdef AXIL_INITIATOR_TIMEOUT_EN
          rsp_timeout_next = 1'b0;
`endif
        end
      RD_ADDR:
        if (AXIL_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
        end
      RD_DATA:
        if (AXIL_rvalid) begin
          rready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = AXIL_rdata;
          rsp_resp_next  = AXIL_rresp;
`ifdef AXIL_INITIATOR_TIMEOUT_EN
          rsp_timeout_next = 1'b0;
`endif
        end
      RESPOND:
        if (rsp_ready) rsp_valid_next = 1'b0;
      default: ;
    endcase
    // Abort wins over any handshake landing on the same edge.
    if (timeout_hit) begin
      awvalid_next   = 1'b0;
      wvalid_next    = 1'b0;
      bready_next    = 1'b0;
      arvalid_next   = 1'b0;
      rready_next    = 1'b0;
      rsp_valid_next = 1'b1;
      rsp_rdata_next = '0;
      rsp_resp_next  = 2'b10;
`ifdef AXIL_INITIATOR_TIMEOUT_EN
      rsp_timeout_next = 1'b1;
`endif
    end
  end

  assign cmd_ready    = cmd_ready_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_rdata    = rsp_rdata_reg;
  assign rsp_resp     = rsp_resp_reg;
  assign AXIL_awaddr  = addr_reg;
  assign AXIL_araddr  = addr_reg;
  assign AXIL_awprot  = PROT;
  assign AXIL_arprot  = PROT;
  assign AXIL_wdata   = wdata_reg;
  assign AXIL_wstrb   = wstrb_reg;
  assign AXIL_awvalid = awvalid_reg;
  assign AXIL_wvalid  = wvalid_reg;
  assign AXIL_bready  = bready_reg;
  assign AXIL_arvalid = arvalid_reg;
  assign AXIL_rready  = rready_reg;

endmodule
